// File: rtl/bmpscan_pkg.sv
// Shared types and constants for the bitmap scan sequencer.
package bmpscan_pkg;

    localparam int NROWS = 64;
    localparam int NCOLS = 24;
    localparam int ROW_W = 6;
    localparam int COL_W = 5;

    localparam logic [ROW_W-1:0] ROW_ZERO = 6'd0;
    localparam logic [ROW_W-1:0] ROW_ONE  = 6'd1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NROWS - 1);
    localparam logic [ROW_W-1:0] COL_LAST = ROW_W'(NCOLS - 1);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_TOP  = 2'd1;
    localparam logic [1:0] SEL_BOT  = 2'd2;
    localparam logic [1:0] SEL_COL  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_LWAIT = 4'd2,
        S_TREQ  = 4'd3,
        S_TWAIT = 4'd4,
        S_TALU  = 4'd5,
        S_BREQ  = 4'd6,
        S_BWAIT = 4'd7,
        S_BALU  = 4'd8,
        S_CREQ  = 4'd9,
        S_CWAIT = 4'd10,
        S_CALU  = 4'd11,
        S_FIN   = 4'd12
    } state_t;

    // States in which the sequencer waits for a bmpreg status strobe.
    function automatic logic is_wait(input state_t s);
        logic r;
        case (s)
            S_LWAIT, S_TWAIT, S_BWAIT, S_CWAIT: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // States in which a slice is presented to the compare ALU.
    function automatic logic is_alu(input state_t s);
        logic r;
        case (s)
            S_TALU, S_BALU, S_CALU: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Slice type associated with the phase a state belongs to.
    function automatic logic [1:0] phase_sel(input state_t s);
        logic [1:0] r;
        case (s)
            S_TREQ, S_TWAIT, S_TALU: r = SEL_TOP;
            S_BREQ, S_BWAIT, S_BALU: r = SEL_BOT;
            S_CREQ, S_CWAIT, S_CALU: r = SEL_COL;
            default:                 r = SEL_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bmpscan_ctrl_slice_hs.sv
// Shared slice handshake: ready-wait timeout counter and ALU done/hit
// qualification. One instance serves all phases; the top muxes the ready.
module bmpscan_slice_hs #(
    parameter int READY_TO = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic ready,
    input  logic slice_valid,
    input  logic alu_done,
    input  logic alu_hit,
    output logic ready_ok,
    output logic timeout,
    output logic slice_done,
    output logic slice_hit
);

    localparam int CNT_W = (READY_TO > 1) ? $clog2(READY_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(READY_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [CNT_W-1:0] wait_cnt_r;

    // Count cycles spent in a wait state without the expected strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (waiting && !ready) begin
            if (wait_cnt_r != CNT_LIMIT) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end
        end else begin
            wait_cnt_r <= CNT_ZERO;
        end
    end

    // Strobe qualification; timeout fires on the last allowed wait cycle.
    always_comb begin
        ready_ok   = waiting & ready;
        timeout    = waiting & ~ready & (wait_cnt_r == CNT_LIMIT);
        slice_done = slice_valid & alu_done;
        slice_hit  = slice_valid & alu_done & alu_hit;
    end

endmodule

// File: rtl/bmpscan_ctrl.sv
// Bitmap scan sequencer: loads bmpreg, runs top-down and bottom-up row scans
// and a column sweep, and gathers the ALU hits into a bounding description.
module bmpscan_ctrl
    import bmpscan_pkg::*;
#(
    parameter int READY_TO = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             wren,
    output logic             nextrowtop,
    output logic             nextrowbot,
    output logic             nextcol,
    output logic             lastrowtop,
    output logic             lastrowbot,
    input  logic             alustart,
    input  logic             rowtopready,
    input  logic             rowbotready,
    input  logic             colready,
    input  logic             finalcolumn,
    output logic             slice_valid,
    output logic [1:0]       slice_sel,
    input  logic             alu_done,
    input  logic             alu_hit,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             top_found,
    output logic             bot_found,
    output logic [ROW_W-1:0] top_row,
    output logic [ROW_W-1:0] bot_row,
    output logic [NCOLS-1:0] col_mask
);

    state_t state_r;
    state_t state_nxt;

    logic [ROW_W-1:0] idx_r;

    logic hs_waiting_s;
    logic hs_ready_s;
    logic ready_ok_s;
    logic timeout_s;
    logic slice_done_s;
    logic slice_hit_s;

    logic       wren_nxt, nextrowtop_nxt, nextrowbot_nxt, nextcol_nxt;
    logic       slice_valid_nxt, busy_nxt, done_nxt;
    logic [1:0] slice_sel_nxt;

    logic             wren_r, nextrowtop_r, nextrowbot_r, nextcol_r;
    logic             slice_valid_r, busy_r, done_r, err_r;
    logic [1:0]       slice_sel_r;
    logic             lastrowtop_r, lastrowbot_r;
    logic             top_found_r, bot_found_r;
    logic [ROW_W-1:0] top_row_r, bot_row_r;
    logic [NCOLS-1:0] col_mask_r;

    // Route the status strobe of the current phase into the shared handshake.
    always_comb begin
        hs_waiting_s = is_wait(state_r);
        hs_ready_s   = 1'b0;
        case (state_r)
            S_LWAIT: hs_ready_s = alustart;
            S_TWAIT: hs_ready_s = rowtopready;
            S_BWAIT: hs_ready_s = rowbotready;
            S_CWAIT: begin
                // Column 0 is never requested; bmpreg signals it via finalcolumn.
                if (idx_r == ROW_ZERO) begin
                    hs_ready_s = finalcolumn;
                end else begin
                    hs_ready_s = colready;
                end
            end
            default: hs_ready_s = 1'b0;
        endcase
    end

    bmpscan_slice_hs #(
        .READY_TO (READY_TO)
    ) u_hs (
        .clk         (clk),
        .rst         (rst),
        .waiting     (hs_waiting_s),
        .ready       (hs_ready_s),
        .slice_valid (slice_valid_r),
        .alu_done    (alu_done),
        .alu_hit     (alu_hit),
        .ready_ok    (ready_ok_s),
        .timeout     (timeout_s),
        .slice_done  (slice_done_s),
        .slice_hit   (slice_hit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic for the load / top / bottom / column sequence.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
                else       state_nxt = S_IDLE;
            end
            S_LOAD: state_nxt = S_LWAIT;
            S_LWAIT: begin
                if (ready_ok_s)     state_nxt = S_TREQ;
                else if (timeout_s) state_nxt = S_FIN;
                else                state_nxt = S_LWAIT;
            end
            S_TREQ: state_nxt = S_TWAIT;
            S_TWAIT: begin
                if (ready_ok_s)     state_nxt = S_TALU;
                else if (timeout_s) state_nxt = S_FIN;
                else                state_nxt = S_TWAIT;
            end
            S_TALU: begin
                if (!slice_done_s)          state_nxt = S_TALU;
                else if (slice_hit_s)       state_nxt = S_BREQ;
                else if (idx_r == ROW_ZERO) state_nxt = S_FIN;   // empty bitmap
                else                        state_nxt = S_TREQ;
            end
            S_BREQ: state_nxt = S_BWAIT;
            S_BWAIT: begin
                if (ready_ok_s)     state_nxt = S_BALU;
                else if (timeout_s) state_nxt = S_FIN;
                else                state_nxt = S_BWAIT;
            end
            S_BALU: begin
                if (!slice_done_s)          state_nxt = S_BALU;
                else if (slice_hit_s)       state_nxt = S_CREQ;
                else if (idx_r == ROW_LAST) state_nxt = S_FIN;
                else                        state_nxt = S_BREQ;
            end
            S_CREQ: state_nxt = S_CWAIT;
            S_CWAIT: begin
                if (ready_ok_s)     state_nxt = S_CALU;
                else if (timeout_s) state_nxt = S_FIN;
                else                state_nxt = S_CWAIT;
            end
            S_CALU: begin
                if (!slice_done_s)          state_nxt = S_CALU;
                else if (idx_r == ROW_ZERO) state_nxt = S_FIN;
                else                        state_nxt = S_CREQ;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        wren_nxt        = (state_nxt == S_LOAD);
        nextrowtop_nxt  = (state_nxt == S_TREQ);
        nextrowbot_nxt  = (state_nxt == S_BREQ);
        // Entering CREQ from column 1 means column 0 is next: no request.
        nextcol_nxt     = (state_nxt == S_CREQ) &&
                          !((state_r == S_CALU) && (idx_r == ROW_ONE));
        slice_valid_nxt = is_alu(state_nxt);
        slice_sel_nxt   = phase_sel(state_nxt);
        busy_nxt        = (state_nxt != S_IDLE) && (state_nxt != S_FIN);
        done_nxt        = (state_nxt == S_FIN);
    end

    // Output registers for strobes and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            wren_r        <= 1'b0;
            nextrowtop_r  <= 1'b0;
            nextrowbot_r  <= 1'b0;
            nextcol_r     <= 1'b0;
            slice_valid_r <= 1'b0;
            slice_sel_r   <= SEL_NONE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            wren_r        <= wren_nxt;
            nextrowtop_r  <= nextrowtop_nxt;
            nextrowbot_r  <= nextrowbot_nxt;
            nextcol_r     <= nextcol_nxt;
            slice_valid_r <= slice_valid_nxt;
            slice_sel_r   <= slice_sel_nxt;
            busy_r        <= busy_nxt;
            done_r        <= done_nxt;
        end
    end

    // Slice index and result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r        <= ROW_ZERO;
            err_r        <= 1'b0;
            lastrowtop_r <= 1'b0;
            lastrowbot_r <= 1'b0;
            top_found_r  <= 1'b0;
            bot_found_r  <= 1'b0;
            top_row_r    <= ROW_ZERO;
            bot_row_r    <= ROW_ZERO;
            col_mask_r   <= {NCOLS{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        err_r        <= 1'b0;
                        lastrowtop_r <= 1'b0;
                        lastrowbot_r <= 1'b0;
                        top_found_r  <= 1'b0;
                        bot_found_r  <= 1'b0;
                        top_row_r    <= ROW_ZERO;
                        bot_row_r    <= ROW_ZERO;
                        col_mask_r   <= {NCOLS{1'b0}};
                    end
                end
                S_LOAD: idx_r <= ROW_LAST;
                S_LWAIT, S_TWAIT, S_BWAIT, S_CWAIT: begin
                    if (timeout_s) begin
                        err_r <= 1'b1;
                    end
                end
                S_TALU: begin
                    if (slice_done_s) begin
                        if (slice_hit_s) begin
                            top_row_r    <= idx_r;
                            top_found_r  <= 1'b1;
                            lastrowtop_r <= 1'b1;
                            idx_r        <= ROW_ZERO;
                        end else if (idx_r == ROW_ZERO) begin
                            lastrowtop_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r - ROW_ONE;
                        end
                    end
                end
                S_BALU: begin
                    if (slice_done_s) begin
                        if (slice_hit_s) begin
                            bot_row_r    <= idx_r;
                            bot_found_r  <= 1'b1;
                            lastrowbot_r <= 1'b1;
                            idx_r        <= COL_LAST;
                        end else if (idx_r == ROW_LAST) begin
                            // Top scan saw a hit, so reaching here is inconsistent.
                            err_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + ROW_ONE;
                        end
                    end
                end
                S_CALU: begin
                    if (slice_done_s) begin
                        if (slice_hit_s) begin
                            col_mask_r[idx_r[COL_W-1:0]] <= 1'b1;
                        end
                        if (idx_r != ROW_ZERO) begin
                            idx_r <= idx_r - ROW_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wren        = wren_r;
    assign nextrowtop  = nextrowtop_r;
    assign nextrowbot  = nextrowbot_r;
    assign nextcol     = nextcol_r;
    assign lastrowtop  = lastrowtop_r;
    assign lastrowbot  = lastrowbot_r;
    assign slice_valid = slice_valid_r;
    assign slice_sel   = slice_sel_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign top_found   = top_found_r;
    assign bot_found   = bot_found_r;
    assign top_row     = top_row_r;
    assign bot_row     = bot_row_r;
    assign col_mask    = col_mask_r;

endmodule

// File: tb/tb_bmpscan_ctrl.sv
// Self-checking bench for bmpscan_ctrl with a behavioural bmpreg/ALU model.
module tb_bmpscan_ctrl;

    localparam int READY_TO = 3;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        wren, nextrowtop, nextrowbot, nextcol, lastrowtop, lastrowbot;
    logic        alustart, rowtopready, rowbotready, colready, finalcolumn;
    logic        slice_valid;
    logic [1:0]  slice_sel;
    logic        alu_done, alu_hit;
    logic        busy, done, err, top_found, bot_found;
    logic [5:0]  top_row, bot_row;
    logic [23:0] col_mask;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] bmp [64];

    typedef struct {
        bit          tf;
        int          tr;
        bit          bf;
        int          br;
        logic [23:0] mask;
    } exp_t;

    typedef struct {
        int   npix;
        int   r0, c0, r1, c1;
        bit   full;
        exp_t e;
    } vec_t;

    bmpscan_ctrl #(.READY_TO(READY_TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .wren(wren), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot), .nextcol(nextcol),
        .lastrowtop(lastrowtop), .lastrowbot(lastrowbot),
        .alustart(alustart), .rowtopready(rowtopready), .rowbotready(rowbotready),
        .colready(colready), .finalcolumn(finalcolumn),
        .slice_valid(slice_valid), .slice_sel(slice_sel),
        .alu_done(alu_done), .alu_hit(alu_hit),
        .busy(busy), .done(done), .err(err),
        .top_found(top_found), .bot_found(bot_found),
        .top_row(top_row), .bot_row(bot_row), .col_mask(col_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {14'd0, wren, nextrowtop, nextrowbot, nextcol, lastrowtop, lastrowbot,
                slice_valid, slice_sel, busy, done, err, top_found, bot_found,
                top_row, bot_row, col_mask};
    endfunction

    // Reference: bounding description of the bitmap computed directly.
    function automatic exp_t ref_model();
        exp_t e;
        e.tf = 1'b0; e.tr = 0; e.bf = 1'b0; e.br = 0; e.mask = 24'd0;
        for (int r = 63; r >= 0; r--) begin
            if (bmp[r] != 24'd0 && !e.tf) begin e.tf = 1'b1; e.tr = r; end
        end
        for (int r = 0; r < 64; r++) begin
            if (bmp[r] != 24'd0 && !e.bf) begin e.bf = 1'b1; e.br = r; end
            e.mask = e.mask | bmp[r];
        end
        return e;
    endfunction

    // ALU answer for the k-th slice of a phase, in scan order.
    function automatic logic model_hit(input int sel, input int k);
        logic h;
        h = 1'b0;
        case (sel)
            1: if (k < 64) h = |bmp[63 - k];
            2: if (k < 64) h = |bmp[k];
            3: if (k < 24) for (int r = 0; r < 64; r++) h = h | bmp[r][23 - k];
            default: h = 1'b0;
        endcase
        return h;
    endfunction

    task automatic clear_bmp();
        for (int r = 0; r < 64; r++) bmp[r] = 24'd0;
    endtask

    task automatic run_scan(input exp_t e, input int rd_max, input int ad_max,
                            input int supp_req, input int rst_col, input bit extra_start);
        int t, start_cyc, wren_cyc, done_cyc, supp_cyc;
        int nwren, ndone, ntreq, nnextcol, ncolrdy, viol, extra, as_cnt, alu_cnt, last_sel, s;
        int ntop, nbot, ncol;
        int nsl [4];
        int rdy_cnt [3];
        bit rdy_pend [3];
        bit alu_act, hit_cur, fc_pend, stop;
        nwren = 0; ndone = 0; ntreq = 0; nnextcol = 0; ncolrdy = 0; viol = 0; extra = 0;
        as_cnt = 0; alu_cnt = 0; last_sel = 0; alu_act = 0; hit_cur = 0; fc_pend = 0; stop = 0;
        wren_cyc = -1; done_cyc = -1; supp_cyc = -1;
        for (int i = 0; i < 4; i++) nsl[i] = 0;
        for (int i = 0; i < 3; i++) begin rdy_cnt[i] = 0; rdy_pend[i] = 0; end

        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        t = 0;
        while (!stop && t < 4000) begin
            @(negedge clk);
            t++;
            start = extra_start && (t == 10);
            rowtopready = 1'b0; rowbotready = 1'b0; colready = 1'b0;
            alu_done = 1'($urandom_range(1, 0));   // noise, only meaningful with slice_valid
            alu_hit  = 1'($urandom_range(1, 0));
            if (fc_pend) begin finalcolumn = 1'b1; fc_pend = 0; end
            if (int'(wren) + int'(nextrowtop) + int'(nextrowbot) + int'(nextcol) > 1) viol++;
            if (nextcol && finalcolumn) viol++;
            // bmpreg: load clears status; alustart follows two cycles later
            if (wren) begin
                nwren++; wren_cyc = cyc; alustart = 1'b0; finalcolumn = 1'b0; as_cnt = 2;
            end else if (as_cnt > 0) begin
                as_cnt--;
                if (as_cnt == 0) alustart = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (rdy_pend[k]) begin
                    if (rdy_cnt[k] == 0) begin
                        rdy_pend[k] = 0;
                        if (k == 0) rowtopready = 1'b1;
                        if (k == 1) rowbotready = 1'b1;
                        if (k == 2) begin
                            colready = 1'b1;
                            ncolrdy++;
                            if (ncolrdy == 23) fc_pend = 1;
                        end
                    end else begin
                        rdy_cnt[k]--;
                    end
                end
            end
            if (nextrowtop) begin
                ntreq++;
                if (ntreq == supp_req) supp_cyc = cyc;
                else begin rdy_pend[0] = 1; rdy_cnt[0] = $urandom_range(rd_max, 0); extra += rdy_cnt[0]; end
            end
            if (nextrowbot) begin
                rdy_pend[1] = 1; rdy_cnt[1] = $urandom_range(rd_max, 0); extra += rdy_cnt[1];
            end
            if (nextcol) begin
                nnextcol++;
                rdy_pend[2] = 1; rdy_cnt[2] = $urandom_range(rd_max, 0); extra += rdy_cnt[2];
            end
            // ALU
            if (slice_valid) begin
                alu_done = 1'b0;
                if (!alu_act) begin
                    alu_act = 1;
                    s = int'(slice_sel);
                    if (s == 0 || s < last_sel) viol++;
                    last_sel = s;
                    hit_cur = model_hit(s, nsl[s]);
                    nsl[s]++;
                    alu_cnt = $urandom_range(ad_max, 0);
                    extra += alu_cnt;
                end
                if (alu_cnt == 0) begin
                    alu_done = 1'b1; alu_hit = hit_cur; alu_act = 0;
                end else begin
                    alu_cnt--;
                end
            end
            if (rst_col > 0 && nsl[3] == rst_col) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_outputs", out_vec(), 64'd0);
                stop = 1;
            end else if (done) begin
                ndone++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 64'd0);
                stop = 1;
            end
        end
        chk("scan_bound", 64'(stop), 64'd1);
        start = 1'b0; alu_done = 1'b0; alu_hit = 1'b0;
        if (rst_col > 0) return;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rowtopready = 1'b0; rowbotready = 1'b0; colready = 1'b0;
            if (done) ndone++;
            if (busy) viol++;
        end

        chk("done_count",   64'(ndone), 64'd1);
        chk("wren_count",   64'(nwren), 64'd1);
        chk("wren_latency", 64'(wren_cyc - start_cyc), 64'd1);
        chk("protocol",     64'(viol), 64'd0);
        chk("top_found",    64'(top_found), 64'(e.tf));
        chk("bot_found",    64'(bot_found), 64'(e.bf));
        chk("col_mask",     64'(col_mask), 64'(e.mask));
        chk("top_row",      64'(top_row), 64'(e.tr));
        chk("bot_row",      64'(bot_row), 64'(e.br));
        if (supp_req > 0) begin
            chk("err_timeout",     64'(err), 64'd1);
            chk("timeout_latency", 64'(done_cyc - supp_cyc), 64'(1 + READY_TO));
            chk("lastrowtop_to",   64'(lastrowtop), 64'd0);
        end else begin
            ntop = e.tf ? 64 - e.tr : 64;
            nbot = e.tf ? e.br + 1 : 0;
            ncol = e.tf ? 24 : 0;
            chk("err",           64'(err), 64'd0);
            chk("top_slices",    64'(nsl[1]), 64'(ntop));
            chk("bot_slices",    64'(nsl[2]), 64'(nbot));
            chk("col_slices",    64'(nsl[3]), 64'(ncol));
            chk("nextcol_count", 64'(nnextcol), 64'(e.tf ? 23 : 0));
            chk("lastrowtop",    64'(lastrowtop), 64'd1);
            chk("lastrowbot",    64'(lastrowbot), 64'(e.bf));
            chk("done_cycle",    64'(done_cyc - wren_cyc), 64'(3 + 3 * (ntop + nbot + ncol) + extra));
        end
    endtask

    initial begin
        vec_t tbl [6];
        exp_t e;
        int npix;

        tbl[0] = '{npix: 0, r0: 0,  c0: 0,  r1: 0,  c1: 0,  full: 1'b0,
                   e: '{tf: 1'b0, tr: 0,  bf: 1'b0, br: 0,  mask: 24'h000000}};
        tbl[1] = '{npix: 1, r0: 40, c0: 5,  r1: 0,  c1: 0,  full: 1'b0,
                   e: '{tf: 1'b1, tr: 40, bf: 1'b1, br: 40, mask: 24'h000020}};
        tbl[2] = '{npix: 0, r0: 0,  c0: 0,  r1: 0,  c1: 0,  full: 1'b1,
                   e: '{tf: 1'b1, tr: 63, bf: 1'b1, br: 0,  mask: 24'hFFFFFF}};
        tbl[3] = '{npix: 1, r0: 0,  c0: 0,  r1: 0,  c1: 0,  full: 1'b0,
                   e: '{tf: 1'b1, tr: 0,  bf: 1'b1, br: 0,  mask: 24'h000001}};
        tbl[4] = '{npix: 1, r0: 63, c0: 23, r1: 0,  c1: 0,  full: 1'b0,
                   e: '{tf: 1'b1, tr: 63, bf: 1'b1, br: 63, mask: 24'h800000}};
        tbl[5] = '{npix: 2, r0: 10, c0: 3,  r1: 50, c1: 20, full: 1'b0,
                   e: '{tf: 1'b1, tr: 50, bf: 1'b1, br: 10, mask: 24'h100008}};

        rst = 1'b1; start = 1'b0;
        alustart = 1'b0; rowtopready = 1'b0; rowbotready = 1'b0; colready = 1'b0;
        finalcolumn = 1'b0; alu_done = 1'b0; alu_hit = 1'b0;
        clear_bmp();
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 64'd0);
        rst = 1'b0;

        // Directed table at minimum latency.
        for (int i = 0; i < 6; i++) begin
            clear_bmp();
            if (tbl[i].full) for (int r = 0; r < 64; r++) bmp[r] = 24'hFFFFFF;
            if (tbl[i].npix > 0) bmp[tbl[i].r0][tbl[i].c0] = 1'b1;
            if (tbl[i].npix > 1) bmp[tbl[i].r1][tbl[i].c1] = 1'b1;
            run_scan(tbl[i].e, 0, 0, 0, 0, 1'b0);
        end

        // rowtopready withheld on the third top request.
        clear_bmp();
        run_scan(ref_model(), 0, 0, 3, 0, 1'b0);

        // Reset during the column sweep, then a normal scan.
        clear_bmp();
        bmp[40][5] = 1'b1;
        run_scan(ref_model(), 0, 0, 0, 10, 1'b0);
        run_scan(ref_model(), 1, 1, 0, 0, 1'b0);

        // start while busy must be ignored.
        clear_bmp();
        bmp[10][3] = 1'b1;
        bmp[50][20] = 1'b1;
        run_scan(ref_model(), 0, 0, 0, 0, 1'b1);

        // Random bitmaps with random ready and ALU latencies.
        for (int n = 0; n < 10; n++) begin
            clear_bmp();
            if (n % 3 == 0) begin
                for (int r = 0; r < 64; r++)
                    if ($urandom_range(3, 0) == 0) bmp[r] = 24'($urandom) & 24'($urandom);
            end else begin
                npix = $urandom_range(4, 0);
                for (int p = 0; p < npix; p++) bmp[$urandom_range(63, 0)][$urandom_range(23, 0)] = 1'b1;
            end
            e = ref_model();
            run_scan(e, 2, 3, 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
